// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU instruction sequencer.
package cpu_seq_pkg;

    // Sequencer control states.
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StHold,
        StDone
    } seq_state_e;

    // Opcode that terminates a run without being issued to the CPU.
    localparam logic [7:0] HaltOpDefault = 8'h00;

    // Width of the CPU latency counter; covers latencies 1..4.
    localparam int unsigned WaitCntW = 3;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Host/CPU side signal bundle of the sequencer.
interface cpu_sequencer_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic [AW-1:0] last_addr;
    logic          start;
    logic          step_mode;
    logic          step;
    logic [7:0]    cpu_res;

    logic [7:0]    instr;
    logic          instr_valid;
    logic [7:0]    result;
    logic          result_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    // Host and CPU stimulus side.
    modport master (
        output load_en, load_addr, load_data, last_addr, start, step_mode, step, cpu_res,
        input  instr, instr_valid, result, result_valid, pc, busy, done
    );

    // Sequencer side.
    modport slave (
        input  load_en, load_addr, load_data, last_addr, start, step_mode, step, cpu_res,
        output instr, instr_valid, result, result_valid, pc, busy, done
    );

endinterface

// File: rtl/seq_prog_ram.sv
// Program buffer: one synchronous write port, one asynchronous read port, DEPTH x 8.
module seq_prog_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    // Contents are deliberately not reset so a program survives a reset.
    logic [7:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Feeds a stored program to a CPU one instruction at a time and captures each result.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CPU_LAT = 1,
    parameter logic [7:0]  HALT_OP = HaltOpDefault
) (
    input logic            clk,
    input logic            rst,
    cpu_sequencer_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Counter value on the cycle the CPU result is valid.
    localparam logic [WaitCntW-1:0] WaitLast = WaitCntW'(CPU_LAT - 1);

    seq_state_e          state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [AW-1:0]       last_q, last_d;
    logic                step_mode_q, step_mode_d;
    logic [7:0]          instr_q, instr_d;
    logic [7:0]          result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic [WaitCntW-1:0] wait_q, wait_d;

    logic                ram_we;
    logic [7:0]          ram_rdata;

    // Loads are accepted only while idle so a running program is never disturbed.
    assign ram_we = bus.load_en && (state_q == StIdle);

    seq_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (bus.load_addr),
        .wdata_i (bus.load_data),
        .raddr_i (pc_q),
        .rdata_o (ram_rdata)
    );

    // State and datapath registers; reset acts immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            pc_q           <= '0;
            last_q         <= '0;
            step_mode_q    <= 1'b0;
            instr_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            wait_q         <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            last_q         <= last_d;
            step_mode_q    <= step_mode_d;
            instr_q        <= instr_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            wait_q         <= wait_d;
        end
    end

    // Next-state and datapath updates for the run sequence.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        last_d         = last_q;
        step_mode_d    = step_mode_q;
        instr_d        = instr_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        wait_d         = wait_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d     = StFetch;
                    pc_d        = '0;
                    last_d      = bus.last_addr;
                    step_mode_d = bus.step_mode;
                end
            end
            StFetch: begin
                if (ram_rdata == HALT_OP) begin
                    state_d = StDone;
                end else begin
                    state_d = StIssue;
                    instr_d = ram_rdata;
                end
            end
            StIssue: begin
                state_d = StWait;
                wait_d  = '0;
            end
            StWait: begin
                if (wait_q == WaitLast) begin
                    wait_d         = '0;
                    result_d       = bus.cpu_res;
                    result_valid_d = 1'b1;
                    if (pc_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = step_mode_q ? StHold : StFetch;
                    end
                end else begin
                    wait_d = wait_q + WaitCntW'(1);
                end
            end
            StHold: begin
                if (bus.step) begin
                    state_d = StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.instr        = instr_q;
    assign bus.instr_valid  = (state_q == StIssue);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.pc           = pc_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StDone);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: event-timing reference model plus directed literal checks.
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LAT   = 1;
    localparam logic [7:0]  HALT  = HaltOpDefault;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_sequencer_if #(.DEPTH(DEPTH)) bus ();
    cpu_sequencer_if #(.DEPTH(DEPTH)) bus3 ();

    cpu_sequencer #(.DEPTH(DEPTH), .CPU_LAT(LAT), .HALT_OP(HALT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    cpu_sequencer #(.DEPTH(DEPTH), .CPU_LAT(3), .HALT_OP(HALT)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: each run is a list of timed events derived from the fetch/issue/wait
    // timing rules (issue one cycle after fetch, result LAT cycles after issue, and so on).
    logic [7:0]    m_mem [DEPTH];
    logic [7:0]    cpu_hist [int];
    bit            m_busy = 1'b0;
    bit            m_step = 1'b0;
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] m_last = '0;
    logic [7:0]    m_instr = '0;
    logic [7:0]    m_result = '0;
    logic [7:0]    pend_instr = '0;
    int busy_on = -1, busy_off = -1, fetch_at = -1, issue_at = -1;
    int rv_at = -1, res_src = -1, pc_inc_at = -1, done_at = -1, hold_from = -1;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_pc = '0; m_instr = '0; m_result = '0;
            busy_on = -1; busy_off = -1; fetch_at = -1; issue_at = -1;
            rv_at = -1; res_src = -1; pc_inc_at = -1; done_at = -1; hold_from = -1;
        end else begin
            cpu_hist[cyc] = bus.cpu_res;
            if (cyc == busy_on) begin m_busy = 1'b1; m_pc = '0; end
            if (cyc == busy_off) m_busy = 1'b0;
            if (cyc == pc_inc_at) m_pc = m_pc + 1'b1;
            if (cyc == issue_at) m_instr = pend_instr;
            if (cyc == rv_at) m_result = cpu_hist[res_src];

            check("instr_valid", bus.instr_valid, cyc == issue_at);
            check("instr", bus.instr, m_instr);
            check("result_valid", bus.result_valid, cyc == rv_at);
            check("result", bus.result, m_result);
            check("done", bus.done, cyc == done_at);
            check("busy", bus.busy, m_busy);
            check("pc", bus.pc, m_pc);

            if (!m_busy && bus.load_en) m_mem[bus.load_addr] = bus.load_data;
            if (!m_busy && bus.start) begin
                busy_on  = cyc + 1;
                fetch_at = cyc + 1;
                m_last   = bus.last_addr;
                m_step   = bus.step_mode;
            end
            if (cyc == fetch_at) begin
                if (m_mem[m_pc] == HALT) begin
                    done_at  = cyc + 1;
                    busy_off = cyc + 2;
                end else begin
                    issue_at   = cyc + 1;
                    pend_instr = m_mem[m_pc];
                    res_src    = cyc + 1 + LAT;
                    rv_at      = cyc + 2 + LAT;
                    if (m_pc == m_last) begin
                        done_at  = cyc + 2 + LAT;
                        busy_off = cyc + 3 + LAT;
                    end else begin
                        pc_inc_at = cyc + 2 + LAT;
                        if (m_step) hold_from = cyc + 2 + LAT;
                        else fetch_at = cyc + 2 + LAT;
                    end
                end
            end
            if (hold_from >= 0 && cyc >= hold_from && bus.step) begin
                fetch_at  = cyc + 1;
                hold_from = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.load_en = 1'b0; bus.start = 1'b0; bus.step = 1'b0;
        bus.cpu_res = 8'($urandom);
        bus3.load_en = 1'b0; bus3.start = 1'b0; bus3.step = 1'b0;
        bus3.cpu_res = 8'($urandom);
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [7:0] d);
        bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
        tick();
    endtask

    task automatic run_start(input logic [AW-1:0] last, input bit sm, output int s);
        bus.start = 1'b1; bus.last_addr = last; bus.step_mode = sm;
        s = cyc;
        tick();
    endtask

    // Follows one run to its done pulse, optionally pulsing step and poking start/load.
    task automatic run_watch(input int s, input int step_pct, input bit poke,
                             output int n_iv, output int n_rv, output int done_k,
                             output logic [7:0] first_instr);
        n_iv = 0; n_rv = 0; done_k = -1; first_instr = 'x;
        for (int k = 0; k < 2000; k++) begin
            if (bus.instr_valid) begin
                if (n_iv == 0) first_instr = bus.instr;
                n_iv++;
            end
            if (bus.result_valid) n_rv++;
            if (bus.done) begin
                done_k = cyc - s;
                tick();
                return;
            end
            if (int'($urandom_range(99)) < step_pct) bus.step = 1'b1;
            if (poke && bus.busy && $urandom_range(3) == 0) begin
                bus.start = 1'b1; bus.load_en = 1'b1; bus.load_data = 8'h55;
                bus.load_addr = AW'($urandom_range(DEPTH - 1));
                bus.last_addr = AW'($urandom_range(DEPTH - 1));
            end
            tick();
        end
        n_checks++; n_fail++;
        $display("FAIL run timeout at cycle %0d: got no done, expected done", cyc);
    endtask

    initial begin
        int s, n_iv, n_rv, dk;
        logic [7:0] fi;
        logic [7:0] prog [4];
        prog = '{8'h9E, 8'h8E, 8'hE4, 8'hF0};
        bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0; bus.last_addr = '0;
        bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.cpu_res = '0;
        bus3.load_en = 0; bus3.load_addr = '0; bus3.load_data = '0; bus3.last_addr = '0;
        bus3.start = 0; bus3.step_mode = 0; bus3.step = 0; bus3.cpu_res = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check("reset busy", bus.busy, 1'b0);
        check("reset pc", bus.pc, 0);
        check("reset instr", bus.instr, 0);
        check("reset result", bus.result, 0);
        check("reset done", bus.done, 1'b0);

        // Fill both buffers; dut3 gets F1 everywhere.
        for (int i = 0; i < DEPTH; i++) begin
            bus3.load_en = 1'b1; bus3.load_addr = AW'(i); bus3.load_data = 8'hF1;
            load_word(AW'(i), 8'($urandom_range(255, 1)));
        end
        for (int i = 0; i < 4; i++) load_word(AW'(i), prog[i]);

        // Free run of four instructions: issues at 2,5,8,11, done at 13.
        run_start(AW'(3), 1'b0, s);
        n_iv = 0; n_rv = 0; dk = -1;
        for (int k = 1; k <= 14; k++) begin
            bit exp_iv;
            exp_iv = (k == 2 || k == 5 || k == 8 || k == 11);
            check("A instr_valid", bus.instr_valid, exp_iv);
            if (exp_iv) begin
                check("A instr", bus.instr, prog[n_iv]);
                n_iv++;
            end
            if (bus.result_valid) n_rv++;
            if (bus.done) dk = k;
            tick();
        end
        check("A results", n_rv, 4);
        check("A done cycle", dk, 13);

        // Halt at address 2.
        load_word(AW'(2), 8'h00);
        run_start(AW'(3), 1'b0, s);
        run_watch(s, 0, 1'b0, n_iv, n_rv, dk, fi);
        check("B issues", n_iv, 2);
        check("B results", n_rv, 2);
        check("B done cycle", dk, 8);
        check("B pc", bus.pc, 2);
        load_word(AW'(2), 8'hE4);

        // Halt at address 0.
        load_word(AW'(0), 8'h00);
        run_start(AW'(3), 1'b0, s);
        run_watch(s, 0, 1'b0, n_iv, n_rv, dk, fi);
        check("H0 issues", n_iv, 0);
        check("H0 results", n_rv, 0);
        check("H0 done cycle", dk, 2);
        load_word(AW'(0), 8'h9E);

        // Step mode; step while idle does nothing.
        for (int i = 0; i < 3; i++) begin bus.step = 1'b1; tick(); end
        check("C idle step busy", bus.busy, 1'b0);
        run_start(AW'(3), 1'b1, s);
        run_watch(s, 30, 1'b0, n_iv, n_rv, dk, fi);
        check("C issues", n_iv, 4);
        check("C results", n_rv, 4);
        check("C first instr", fi, 8'h9E);

        // Asynchronous reset during WAIT of the second instruction.
        run_start(AW'(3), 1'b0, s);
        repeat (5) tick();
        #1 rst = 1'b1;
        #1;
        check("D rst instr", bus.instr, 0);
        check("D rst instr_valid", bus.instr_valid, 1'b0);
        check("D rst result", bus.result, 0);
        check("D rst result_valid", bus.result_valid, 1'b0);
        check("D rst pc", bus.pc, 0);
        check("D rst busy", bus.busy, 1'b0);
        check("D rst done", bus.done, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        run_start(AW'(3), 1'b0, s);
        run_watch(s, 0, 1'b0, n_iv, n_rv, dk, fi);
        check("D rerun issues", n_iv, 4);
        check("D rerun first", fi, 8'h9E);
        check("D rerun done cycle", dk, 13);

        // start and load while busy are ignored; load+start together uses the new word.
        run_start(AW'(3), 1'b0, s);
        run_watch(s, 0, 1'b1, n_iv, n_rv, dk, fi);
        check("E issues", n_iv, 4);
        check("E done cycle", dk, 13);
        run_start(AW'(3), 1'b0, s);
        run_watch(s, 0, 1'b0, n_iv, n_rv, dk, fi);
        check("E buffer intact", fi, 8'h9E);
        bus.load_en = 1'b1; bus.load_addr = '0; bus.load_data = 8'h3C;
        run_start(AW'(0), 1'b0, s);
        run_watch(s, 0, 1'b0, n_iv, n_rv, dk, fi);
        check("E load+start first", fi, 8'h3C);
        check("E load+start issues", n_iv, 1);

        // Randomized runs checked by the model.
        for (int it = 0; it < 40; it++) begin
            int nl;
            nl = int'($urandom_range(3));
            for (int j = 0; j < nl; j++) begin
                load_word(AW'($urandom_range(DEPTH - 1)),
                          ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom));
            end
            if ($urandom_range(3) == 0) begin bus.step = 1'b1; tick(); end
            run_start(AW'($urandom_range(DEPTH - 1)), 1'($urandom), s);
            run_watch(s, 35, 1'($urandom), n_iv, n_rv, dk, fi);
        end

        // Latency 3, full buffer of F1: 16 issues, done at 81.
        s = cyc;
        bus3.start = 1'b1; bus3.last_addr = AW'(DEPTH - 1); bus3.step_mode = 1'b0;
        tick();
        n_iv = 0; n_rv = 0; dk = -1;
        for (int k = 1; k < 200 && dk < 0; k++) begin
            if (bus3.instr_valid) begin
                n_iv++;
                check("G instr", bus3.instr, 8'hF1);
            end
            if (bus3.result_valid) n_rv++;
            if (bus3.done) dk = cyc - s;
            tick();
        end
        check("G issues", n_iv, 16);
        check("G results", n_rv, 16);
        check("G done cycle", dk, 81);
        check("G pc", bus3.pc, 15);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, program buffer entries (power of two, 4..64).
REQ-002 SHALL have parameter CPU_LAT, default 1, cycles from instr issue to valid CPU result (1..4).
REQ-003 SHALL have parameter HALT_OP, default 8'h00, opcode that ends a run without being issued.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port load_en  in  1  write load_data into buffer at load_addr.
REQ-007 SHALL have port load_addr  in  log2(DEPTH)  buffer write address.
REQ-008 SHALL have port load_data  in  8  instruction word to store.
REQ-009 SHALL have port last_addr  in  log2(DEPTH)  final address of the run; sampled on accepted start.
REQ-010 SHALL have port start  in  1  begin a run at address 0.
REQ-011 SHALL have port step_mode  in  1  when 1, one instruction per step pulse; sampled on accepted start.
REQ-012 SHALL have port step  in  1  advance one instruction in step mode.
REQ-013 SHALL have port instr  out  8  instruction driven to the CPU instr input.
REQ-014 SHALL have port instr_valid  out  1  instr is new this cycle.
REQ-015 SHALL have port cpu_res  in  8  CPU result bus.
REQ-016 SHALL have port result  out  8  captured CPU result.
REQ-017 SHALL have port result_valid  out  1  one-cycle pulse, result updated.
REQ-018 SHALL have port pc  out  log2(DEPTH)  address of current/next instruction.
REQ-019 SHALL have port busy  out  1  high in any state except IDLE.
REQ-020 SHALL have port done  out  1  one-cycle pulse at end of run.

Function
REQ-021 SHALL implement states IDLE, FETCH, ISSUE, WAIT, HOLD, DONE.
REQ-022 IDLE: start=1 -> FETCH next cycle, pc=0; last_addr and step_mode latched.
REQ-023 FETCH: buf[pc]==HALT_OP -> DONE, no issue; else -> ISSUE.
REQ-024 ISSUE: instr=buf[pc], instr_valid=1 for exactly one cycle -> WAIT; instr holds its value until next issue.
REQ-025 WAIT: count CPU_LAT cycles after ISSUE, then result<=cpu_res, result_valid pulse.
REQ-026 After capture: pc==latched last_addr -> DONE; else pc<=pc+1 and -> FETCH (step_mode=0) or HOLD (step_mode=1).
REQ-027 HOLD: step=1 -> FETCH; step ignored in every other state.
REQ-028 DONE: done=1 one cycle -> IDLE; pc holds its last value.
REQ-029 Run time with step_mode=0, CPU_LAT=L, N instructions, no halt: start accepted at cycle 0, done high at cycle N*(L+2)+1.
REQ-030 start while busy SHALL be ignored.
REQ-031 load_en while busy SHALL be ignored; in IDLE write completes in one cycle; simultaneous load_en and start: write occurs, run starts, first FETCH reads new data.
REQ-032 last_addr=DEPTH-1 SHALL run all entries; pc never wraps past last_addr.
REQ-033 HALT_OP at address 0 SHALL give done with no instr_valid and no result_valid.

Reset
REQ-034 rst SHALL force IDLE immediately regardless of clk, including mid-run.
REQ-035 On reset: instr=0, instr_valid=0, result=0, result_valid=0, pc=0, busy=0, done=0, wait counter=0.
REQ-036 Program buffer contents SHALL not be cleared by reset.

Structure
REQ-037 State encoding and HALT_OP default SHALL live in shared package cpu_seq_pkg.
REQ-038 Program buffer SHALL be sub-module seq_prog_ram (1 write port, 1 async read port, DEPTH x 8).

Verification
REQ-039 Load 9E,8E,E4,F0 at 0..3, last_addr=3, step_mode=0, L=1, start -> instr_valid at cycles 2,5,8,11 with 9E,8E,E4,F0; four result_valid; done at cycle 13.
REQ-040 Same program, buf[2]=00 -> two issues (9E,8E), two results, done, pc=2.
REQ-041 step_mode=1, same program -> one issue per step pulse; step with no run ignored; done after fourth result.
REQ-042 Assert rst during WAIT of second instruction -> all outputs reset values within same cycle; subsequent start reruns from pc=0 with buffer intact.
REQ-043 start pulsed during run and load_en during run -> no restart, buffer unchanged; load_en+start same cycle in IDLE -> new word issued first.
REQ-044 DEPTH=16, last_addr=15, all entries F1, L=3 -> 16 issues, done at cycle 16*5+1=81, pc=15.
